// File: rtl/kv_cache_pkg.sv
// Shared types for the key-value cache engine: operation codes, control states
// and the response flag bundle registered at the end of EXEC.
package kv_cache_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_GET   = 2'd0,
        OP_PUT   = 2'd1,
        OP_DEL   = 2'd2,
        OP_FLUSH = 2'd3
    } kv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } kv_state_e;

    typedef struct packed {
        logic hit;
        logic evicted;
        logic full;
    } kv_rsp_t;

endpackage

// File: rtl/kv_lru_tracker.sv
// Age-based LRU bookkeeping: ages form a permutation of 0..NUM_ENTRIES-1 and the
// slot holding the oldest age is reported as the eviction victim.
module kv_lru_tracker #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_touch,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_touch_idx,
    input  logic                           i_flush,
    output logic [NUM_ENTRIES-1:0]         o_victim_oh
);
    localparam int AW = $clog2(NUM_ENTRIES);

    logic [AW-1:0] r_age [NUM_ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= AW'(i);
        end else if (i_flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= AW'(i);
        end else if (i_touch) begin
            // Only slots younger than the touched one age, keeping the permutation intact.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (AW'(i) == i_touch_idx) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < r_age[i_touch_idx]) begin
                    r_age[i] <= r_age[i] + AW'(1);
                end
            end
        end
    end

    always_comb begin
        o_victim_oh = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            o_victim_oh[i] = (r_age[i] == AW'(NUM_ENTRIES - 1));
        end
    end

endmodule

// File: rtl/kv_cache_engine.sv
// Key-value cache engine: fully associative storage with GET/PUT/DEL/FLUSH behind
// a request/response channel; a full-cache PUT miss evicts the LRU slot or is refused.
module kv_cache_engine
    import kv_cache_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 32,
    parameter int EVICT_EN    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [OP_W-1:0]                  req_op_i,
    input  logic [KEY_WIDTH-1:0]             req_key_i,
    input  logic [VALUE_WIDTH-1:0]           req_value_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic                             rsp_hit_o,
    output logic [VALUE_WIDTH-1:0]           rsp_value_o,
    output logic                             rsp_evicted_o,
    output logic                             rsp_full_o,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] used_count_o,
    output kv_state_e                        o_dbg_state
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int CW = $clog2(NUM_ENTRIES + 1);

    kv_state_e              r_state, w_state_nxt;
    kv_op_e                 r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [KEY_WIDTH-1:0]   r_keys [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] r_vals [NUM_ENTRIES];
    kv_rsp_t                r_rsp;
    logic [VALUE_WIDTH-1:0] r_rsp_value;

    logic [NUM_ENTRIES-1:0] w_match, w_victim_oh;
    logic [AW-1:0]          w_match_idx, w_free_idx, w_victim_idx, w_wr_idx, w_touch_idx;
    logic                   w_hit, w_has_free;
    logic                   w_write, w_touch, w_evict, w_full, w_del, w_flush;

    // Handshakes: a request transfers on a cycle where req_valid_i && req_ready_o;
    // a response transfers where rsp_valid_o && rsp_ready_i. Both sides hold until then.
    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_match      = '0;
        w_match_idx  = '0;
        w_free_idx   = '0;
        w_victim_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = r_valid[i] && (r_keys[i] == r_key);
            if (w_match[i]) w_match_idx = AW'(i);
            if (w_victim_oh[i]) w_victim_idx = AW'(i);
        end
        // Descending scan leaves the lowest free index.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = AW'(i);
        end
    end

    assign w_hit      = |w_match;
    assign w_has_free = ~&r_valid;

    always_comb begin
        w_write     = 1'b0;
        w_wr_idx    = w_match_idx;
        w_touch     = 1'b0;
        w_touch_idx = w_match_idx;
        w_evict     = 1'b0;
        w_full      = 1'b0;
        w_del       = 1'b0;
        w_flush     = 1'b0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_GET: w_touch = w_hit;
                OP_PUT: begin
                    if (w_hit) begin
                        w_write = 1'b1;
                    end else if (w_has_free) begin
                        w_write  = 1'b1;
                        w_wr_idx = w_free_idx;
                    end else if (EVICT_EN != 0) begin
                        w_write  = 1'b1;
                        w_wr_idx = w_victim_idx;
                        w_evict  = 1'b1;
                    end else begin
                        w_full = 1'b1;
                    end
                    w_touch     = w_write;
                    w_touch_idx = w_wr_idx;
                end
                OP_DEL:   w_del   = w_hit;
                OP_FLUSH: w_flush = 1'b1;
                default:  w_touch = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_GET;
            r_key       <= '0;
            r_value     <= '0;
            r_rsp       <= '0;
            r_rsp_value <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && req_valid_i) begin
                r_op    <= kv_op_e'(req_op_i);
                r_key   <= req_key_i;
                r_value <= req_value_i;
            end
            if (r_state == ST_EXEC) begin
                r_rsp.hit     <= w_hit && (r_op != OP_FLUSH);
                r_rsp.evicted <= w_evict;
                r_rsp.full    <= w_full;
                r_rsp_value   <= (r_op == OP_GET && w_hit) ? r_vals[w_match_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_keys[i] <= '0;
                r_vals[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid <= '0;
        end else begin
            if (w_write) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_keys[w_wr_idx]  <= r_key;
                r_vals[w_wr_idx]  <= r_value;
            end
            if (w_del) r_valid[w_match_idx] <= 1'b0;
        end
    end

    kv_lru_tracker #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_touch    (w_touch),
        .i_touch_idx(w_touch_idx),
        .i_flush    (w_flush),
        .o_victim_oh(w_victim_oh)
    );

    always_comb begin
        used_count_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            used_count_o = used_count_o + CW'(r_valid[i]);
        end
    end

    assign rsp_hit_o     = r_rsp.hit;
    assign rsp_evicted_o = r_rsp.evicted;
    assign rsp_full_o    = r_rsp.full;
    assign rsp_value_o   = r_rsp_value;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_kv_cache_engine.sv
// Bench for kv_cache_engine: an evicting and a refusing instance share one request
// stream and are compared every cycle against a recency-list model of the cache.
module tb_kv_cache_engine;
    import kv_cache_pkg::*;

    localparam int N  = 4;
    localparam int KW = 16;
    localparam int VW = 32;
    localparam int CW = $clog2(N + 1);
    localparam int RW = VW + 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic [1:0]    req_op    = '0;
    logic [KW-1:0] req_key   = '0;
    logic [VW-1:0] req_value = '0;
    logic          rsp_ready = 1'b0;

    logic          req_ready [2];
    logic          rsp_valid [2];
    logic          rsp_hit   [2];
    logic          rsp_ev    [2];
    logic          rsp_full  [2];
    logic [VW-1:0] rsp_value [2];
    logic [CW-1:0] used_count[2];
    kv_state_e     dbg_state [2];

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0 evicts on a full-cache miss, instance 1 refuses.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        kv_cache_engine #(
            .NUM_ENTRIES(N),
            .KEY_WIDTH  (KW),
            .VALUE_WIDTH(VW),
            .EVICT_EN   ((g == 0) ? 1 : 0)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid_i  (req_valid),
            .req_ready_o  (req_ready[g]),
            .req_op_i     (req_op),
            .req_key_i    (req_key),
            .req_value_i  (req_value),
            .rsp_valid_o  (rsp_valid[g]),
            .rsp_ready_i  (rsp_ready),
            .rsp_hit_o    (rsp_hit[g]),
            .rsp_value_o  (rsp_value[g]),
            .rsp_evicted_o(rsp_ev[g]),
            .rsp_full_o   (rsp_full[g]),
            .used_count_o (used_count[g]),
            .o_dbg_state  (dbg_state[g])
        );
    end

    always #5 clk = ~clk;

    // Model: slot contents plus a recency list (m_order[d][0] is most recent).
    logic          m_valid [2][N];
    logic [KW-1:0] m_key   [2][N];
    logic [VW-1:0] m_val   [2][N];
    int            m_order [2][N];
    int            phase;
    logic [1:0]    l_op;
    logic [KW-1:0] l_key;
    logic [VW-1:0] l_val;
    logic [RW-1:0] exp_q0[$];
    logic [RW-1:0] exp_q1[$];

    logic          last_hit [2];
    logic          last_ev  [2];
    logic          last_full[2];
    logic [VW-1:0] last_val [2];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_valid[d][i] = 1'b0;
                m_key[d][i]   = '0;
                m_val[d][i]   = '0;
                m_order[d][i] = i;
            end
        end
        exp_q0.delete();
        exp_q1.delete();
        phase = 0;
    endfunction

    function automatic int m_count(input int d);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[d][i]);
        return c;
    endfunction

    function automatic void touch(input int d, input int s);
        int p = 0;
        for (int i = 0; i < N; i++) if (m_order[d][i] == s) p = i;
        for (int i = p; i > 0; i--) m_order[d][i] = m_order[d][i-1];
        m_order[d][0] = s;
    endfunction

    function automatic void apply(input int d, input logic [1:0] op, input logic [KW-1:0] key,
                                  input logic [VW-1:0] val);
        int m = -1, f = -1, w = -1;
        logic hit = 1'b0, ev = 1'b0, full = 1'b0;
        logic [VW-1:0] rv = '0;
        for (int i = 0; i < N; i++) if (m_valid[d][i] && m_key[d][i] == key) m = i;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[d][i]) f = i;
        hit = (m >= 0) && (op != OP_FLUSH);
        case (op)
            OP_GET: if (hit) begin
                rv = m_val[d][m];
                touch(d, m);
            end
            OP_PUT: begin
                if (hit) w = m;
                else if (f >= 0) w = f;
                else if (d == 0) begin
                    w  = m_order[d][N-1];
                    ev = 1'b1;
                end else full = 1'b1;
                if (w >= 0) begin
                    m_valid[d][w] = 1'b1;
                    m_key[d][w]   = key;
                    m_val[d][w]   = val;
                    touch(d, w);
                end
            end
            OP_DEL: if (hit) m_valid[d][m] = 1'b0;
            default: for (int i = 0; i < N; i++) begin
                m_valid[d][i] = 1'b0;
                m_order[d][i] = i;
            end
        endcase
        if (d == 0) exp_q0.push_back({hit, ev, full, rv});
        else        exp_q1.push_back({hit, ev, full, rv});
    endfunction

    // Transaction timing: accept, one execute cycle, then response until consumed.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                case (phase)
                    0: if (req_valid) begin
                        l_op  = req_op;
                        l_key = req_key;
                        l_val = req_value;
                        phase = 1;
                    end
                    1: begin
                        apply(0, l_op, l_key, l_val);
                        apply(1, l_op, l_key, l_val);
                        phase = 2;
                    end
                    default: if (rsp_ready) begin
                        void'(exp_q0.pop_front());
                        void'(exp_q1.pop_front());
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("req_ready_i%0d", d), req_ready[d], phase == 0);
                check($sformatf("rsp_valid_i%0d", d), rsp_valid[d], phase == 2);
                check($sformatf("used_i%0d", d), used_count[d], m_count(d));
                check($sformatf("state_i%0d", d), dbg_state[d],
                      (phase == 0) ? ST_IDLE : (phase == 1) ? ST_EXEC : ST_RESP);
                if (phase == 2) begin
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check($sformatf("exp_q_i%0d", d), 0, 1);
                    end else begin
                        e = (d == 0) ? exp_q0[0] : exp_q1[0];
                        check($sformatf("rsp_i%0d", d),
                              {rsp_hit[d], rsp_ev[d], rsp_full[d], rsp_value[d]}, e);
                    end
                end
            end
        end
    end

    // Issues one request at a negedge with the engine idle; returns at a negedge, idle again.
    task automatic txn(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                       input int hold);
        int waited = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom_range(0, 3));
        req_key   = KW'($urandom);
        req_value = $urandom;
        while (!rsp_valid[0] && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_latency", waited, 1);
        for (int d = 0; d < 2; d++) begin
            last_hit[d]  = rsp_hit[d];
            last_ev[d]   = rsp_ev[d];
            last_full[d] = rsp_full[d];
            last_val[d]  = rsp_value[d];
        end
        repeat (hold) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_key   = KW'($urandom);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string name, input int d, input logic hit, input logic ev,
                             input logic full, input logic [VW-1:0] val);
        check($sformatf("%s_i%0d", name, d),
              {last_hit[d], last_ev[d], last_full[d], last_val[d]}, {hit, ev, full, val});
    endtask

    task automatic check_used(input string name, input int n);
        for (int d = 0; d < 2; d++) check($sformatf("%s_i%0d", name, d), used_count[d], n);
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_rsp_i%0d", d), {rsp_valid[d], rsp_hit[d], rsp_ev[d], rsp_full[d], rsp_value[d]}, 0);
            check($sformatf("rst_ready_i%0d", d), req_ready[d], 1);
        end
        check_used("rst_used", 0);
        rst_n = 1'b1;

        txn(OP_GET, 16'h0001, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("get_empty", d, 0, 0, 0, 0);
        txn(OP_PUT, 16'h0001, 32'hDEADBEEF, 0);
        txn(OP_GET, 16'h0001, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("get_hit", d, 1, 0, 0, 32'hDEADBEEF);
        check_used("used_one", 1);

        txn(OP_PUT, 16'd1, 32'h11, 0);
        for (int d = 0; d < 2; d++) check_rsp("put_overwrite", d, 1, 0, 0, 0);
        txn(OP_PUT, 16'd2, 32'h22, 0);
        txn(OP_PUT, 16'd3, 32'h33, 0);
        txn(OP_PUT, 16'd4, 32'h44, 0);
        txn(OP_GET, 16'd1, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("get_1", d, 1, 0, 0, 32'h11);
        txn(OP_PUT, 16'd5, 32'h55, 0);
        check_rsp("put_evict", 0, 0, 1, 0, 0);
        check_rsp("put_full", 1, 0, 0, 1, 0);
        check_used("used_full", 4);
        txn(OP_GET, 16'd2, 0, 0);
        check_rsp("get_evicted", 0, 0, 0, 0, 0);
        check_rsp("get_kept", 1, 1, 0, 0, 32'h22);
        txn(OP_GET, 16'd1, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("get_recent", d, 1, 0, 0, 32'h11);
        txn(OP_GET, 16'd5, 0, 0);
        check_rsp("get_5", 0, 1, 0, 0, 32'h55);
        check_rsp("get_5", 1, 0, 0, 0, 0);

        txn(OP_DEL, 16'd3, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("del_hit", d, 1, 0, 0, 0);
        check_used("used_del", 3);
        txn(OP_PUT, 16'd6, 32'h66, 0);
        for (int d = 0; d < 2; d++) check_rsp("put_reuse", d, 0, 0, 0, 0);
        check_used("used_reuse", 4);
        txn(OP_FLUSH, 16'd0, 0, 0);
        check_used("used_flush", 0);
        txn(OP_GET, 16'd6, 0, 0);
        for (int d = 0; d < 2; d++) check_rsp("get_flushed", d, 0, 0, 0, 0);

        txn(OP_PUT, 16'd7, 32'h77, 5);
        check_used("used_hold", 1);

        // Reset in the middle of the execute cycle of a PUT.
        req_valid = 1'b1;
        req_op    = OP_PUT;
        req_key   = 16'd9;
        req_value = 32'h99;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("midrst_valid_i%0d", d), rsp_valid[d], 0);
        check_used("midrst_used", 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 15);
            txn((r < 6) ? OP_GET : (r < 12) ? OP_PUT : (r < 15) ? OP_DEL : OP_FLUSH,
                KW'($urandom_range(1, 6)), $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kv_cache_engine.md
# kv_cache_engine

Parametrised key-value cache engine: the next generation of the cache datapath, merging lookup, storage and control into one block behind a valid/ready request/response channel. Adds a FLUSH operation, full-cache reporting and optional least-recently-used eviction when a PUT misses on a full cache. Sits between the OBI register interface and the rest of the system; the OBI front-end drives requests and collects responses.

## Interface
- NUM_ENTRIES, 8: number of cache slots, ≥2, power of two.
- KEY_WIDTH, 16: key width in bits.
- VALUE_WIDTH, 32: value width in bits.
- EVICT_EN, 1: 1 = a PUT on a full cache evicts the LRU slot; 0 = the PUT is refused with full flag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_op_i  in  2  operation: GET=0, PUT=1, DEL=2, FLUSH=3.
- req_key_i  in  KEY_WIDTH  key (ignored for FLUSH).
- req_value_i  in  VALUE_WIDTH  value (PUT only).
- rsp_valid_o  out  1  response valid; held until rsp_ready_i.
- rsp_ready_i  in  1  response consumed.
- rsp_hit_o  out  1  key was present before the operation.
- rsp_value_o  out  VALUE_WIDTH  GET hit: stored value; otherwise 0.
- rsp_evicted_o  out  1  PUT displaced a valid entry.
- rsp_full_o  out  1  PUT refused (EVICT_EN=0, cache full, miss).
- used_count_o  out  $clog2(NUM_ENTRIES+1)  number of valid slots.

## Operation
- FSM states IDLE, EXEC, RESP. IDLE: req_ready_o=1; on handshake, latch op/key/value, go EXEC. EXEC: one cycle, match computed from latched key against valid slots, state updated at end of cycle, go RESP. RESP: rsp_valid_o=1; on rsp_ready_i go IDLE.
- Match: at most one slot holds a given key; one-hot match vector.
- GET hit: return value, touch slot. GET miss: hit=0, value=0, no state change.
- PUT hit: overwrite value, touch slot, hit=1. PUT miss: write lowest-index free slot; else if EVICT_EN write slot with age NUM_ENTRIES-1, evicted=1; else full=1, no write. Written slot is touched.
- DEL hit: clear valid bit, hit=1; ages unchanged. DEL miss: hit=0, no change.
- FLUSH: clear all valid bits, ages reset to slot index; hit=0.
- LRU: ages are a permutation of 0..NUM_ENTRIES-1 over all slots, width $clog2(NUM_ENTRIES). Touching slot s with age a: slot s age←0; every slot with age < a increments. Reset and FLUSH: age[i]=i.
- used_count_o updates at end of EXEC; equals popcount of valid bits.

## Timing
- Reset: state IDLE, all valid bits 0, age[i]=i, stored keys/values 0, req_ready_o=1, rsp_valid_o=0, all rsp_* 0, used_count_o=0.
- Request accepted at edge E0; EXEC cycle between E0 and E1; rsp_valid_o high from E1. Minimum issue interval 3 cycles (accept, EXEC, RESP with rsp_ready_i high).
- rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
- req_ready_o=0 in EXEC and RESP; inputs ignored there.
- Reset asserted mid-operation: immediate return to reset state; pending response discarded.
- Back-to-back identical PUT key: second sees hit=1.

## Structure
- Shared package kv_cache_pkg: op enum (GET/PUT/DEL/FLUSH), FSM state enum, response struct.
- Sub-module kv_lru_tracker: holds age array, inputs touch/touch_idx/flush, outputs victim one-hot (age NUM_ENTRIES-1).
- Storage and match logic in kv_cache_engine.

## Test plan
(NUM_ENTRIES=4, EVICT_EN=1 unless stated.)
- After reset GET key 0x0001 -> hit=0, value=0, used_count=0; response valid exactly at E1.
- PUT 0x0001=0xDEADBEEF, GET 0x0001 -> hit=1, value=0xDEADBEEF; used_count=1.
- PUT keys 1,2,3,4; GET 1; PUT 5 -> evicted=1; GET 2 -> hit=0; GET 1 -> hit=1.
- EVICT_EN=0: fill 4 keys, PUT 5 -> full=1, used_count=4, GET 5 -> hit=0.
- DEL 3 -> hit=1, used_count drops by 1; next PUT 6 reuses freed slot, evicted=0; FLUSH -> used_count=0, GET 6 -> hit=0.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0; assert rst_n low mid-EXEC -> rsp_valid_o=0, used_count=0.
